// File: rtl/cpu_exec_ctrl_pkg.sv
// cpu_dbg_pkg: shared definitions for the RV32I execution controller.
//   exec_state_t  - controller state encoding, also visible on the state output
//   EBREAK_INSTR  - encoding of the EBREAK instruction that halts free-run
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BREAK = 2'd3
  } exec_state_t;

  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

endpackage

// File: rtl/cpu_exec_ctrl_if.sv
// cpu_exec_ctrl_if: core-side bundle between the execution controller and
// the RV32I core / debug configuration.
//   bp_en, bp_addr      breakpoint configuration (static)
//   pc, instr           current core PC and the instruction at it
//   cpu_en              one-cycle advance pulse to the core
//   state, halted       controller status
//   instr_count         cpu_en pulses issued since reset
// master = core/config side, slave = controller.
interface cpu_exec_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [31:0]      pc;
  logic [31:0]      instr;
  logic             cpu_en;
  logic [1:0]       state;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output bp_en, bp_addr, pc, instr,
    input  cpu_en, state, halted, instr_count
  );

  modport slave (
    input  bp_en, bp_addr, pc, instr,
    output cpu_en, state, halted, instr_count
  );
endinterface

// File: rtl/cpu_exec_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchronizer and debouncer for an active-low pushbutton.
//   clk, rst    clock, synchronous active-high reset
//   btn_n       raw asynchronous, bouncy button (active-low)
//   level       debounced button level
//   press       one-cycle pulse on a debounced 1->0 transition
// The counter tracks how many consecutive cycles the synced level has held,
// counting the current cycle; the stable level follows once that run reaches
// DEBOUNCE_CYCLES. Releases update the level silently.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

  logic          sync_meta;
  logic          sync_s;
  logic          last_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] held;

  // Run length including this cycle; saturates so a long hold cannot wrap.
  always_comb begin
    held = CW'(1);
    if (sync_s == last_q) begin
      if (cnt_q == CNT_DONE) held = CNT_DONE;
      else                   held = cnt_q + 1'b1;
    end
  end

  // Button idles released (high), so reset loads that level to avoid a false press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b1;
      sync_s    <= 1'b1;
      last_q    <= 1'b1;
      stable_q  <= 1'b1;
      cnt_q     <= '0;
    end else begin
      sync_meta <= btn_n;
      sync_s    <= sync_meta;
      last_q    <= sync_s;
      cnt_q     <= held;
      if (held == CNT_DONE) stable_q <= sync_s;
    end
  end

  assign press = (held == CNT_DONE) && !sync_s && stable_q;
  assign level = stable_q;

endmodule

// File: rtl/cpu_exec_ctrl.sv
// cpu_exec_ctrl: execution controller for the single-cycle RV32I core.
// Produces a registered one-cycle cpu_en pulse for single-step, divided
// free-run, and halts on a PC breakpoint or EBREAK.
//   clk, rst     clock, synchronous active-high reset
//   step_btn_n   raw step pushbutton, active-low
//   run_sw       raw run switch, 1 = free-run
//   bus          core-side bundle (slave): bp_en, bp_addr, pc, instr in;
//                cpu_en, state, halted, instr_count out
//
// state | meaning
// ------+-------------------------------------------------------------
// HALT  | idle; press -> STEP, run switch -> RUN
// RUN   | free-run, one pulse per RUN_DIV cycles unless bp/EBREAK hit
// STEP  | cpu_en high this cycle, then HALT
// BREAK | stopped at bp/EBREAK; press single-steps past it
module cpu_exec_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int RUN_DIV         = 5_000_000,
  parameter int CNT_W           = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           step_btn_n,
  input  logic           run_sw,
  cpu_exec_ctrl_if.slave bus
);
  localparam logic [1:0] ST_HALT  = 2'(HALT);
  localparam logic [1:0] ST_RUN   = 2'(RUN);
  localparam logic [1:0] ST_STEP  = 2'(STEP);
  localparam logic [1:0] ST_BREAK = 2'(BREAK);

  localparam int DIV_W = $clog2(RUN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  logic             press;
  logic             btn_level;
  logic             run_meta;
  logic             run_s;
  logic [1:0]       state_q, next_state;
  logic [DIV_W-1:0] div_q, next_div;
  logic             cpu_en_q, next_en;
  logic [CNT_W-1:0] count_q;
  logic             bp_hit;
  logic             ebrk;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk   (clk),
    .rst   (rst),
    .btn_n (step_btn_n),
    .level (btn_level),
    .press (press)
  );

  assign bp_hit = bus.bp_en && (bus.pc == bus.bp_addr);
  assign ebrk   = (bus.instr == EBREAK_INSTR);

  always_comb begin
    next_state = state_q;
    next_div   = div_q;
    next_en    = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (press) begin
          next_state = ST_STEP;
          next_en    = 1'b1;
        end else if (run_s) begin
          next_state = ST_RUN;
          next_div   = '0;
        end
      end
      ST_STEP: next_state = ST_HALT;
      ST_RUN: begin
        if (!run_s) begin
          next_state = ST_HALT;
        end else if (div_q == DIV_LAST) begin
          next_div = '0;
          // Stop before issuing the pulse so the matching instruction stays unexecuted.
          if (bp_hit || ebrk) next_state = ST_BREAK;
          else                next_en    = 1'b1;
        end else begin
          next_div = div_q + 1'b1;
        end
      end
      ST_BREAK: begin
        if (!run_s) begin
          next_state = ST_HALT;
        end else if (press) begin
          next_state = ST_STEP;
          next_en    = 1'b1;
        end
      end
      default: next_state = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_meta <= 1'b0;
      run_s    <= 1'b0;
      state_q  <= ST_HALT;
      div_q    <= '0;
      cpu_en_q <= 1'b0;
      count_q  <= '0;
    end else begin
      run_meta <= run_sw;
      run_s    <= run_meta;
      state_q  <= next_state;
      div_q    <= next_div;
      cpu_en_q <= next_en;
      if (cpu_en_q) count_q <= count_q + 1'b1;
    end
  end

  assign bus.cpu_en      = cpu_en_q;
  assign bus.state       = state_q;
  assign bus.halted      = (state_q != ST_RUN);
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
module tb_cpu_exec_ctrl;
  import cpu_dbg_pkg::*;

  localparam int CNT_W = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  logic step_btn_n;
  logic run_sw;
  logic core_rst;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_exec_ctrl_if #(.CNT_W(CNT_W)) bus ();

  cpu_exec_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV        (3),
    .CNT_W          (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .step_btn_n (step_btn_n),
    .run_sw     (run_sw),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Core model: PC advances by 4 on every cpu_en cycle.
  always @(posedge clk) begin
    if (core_rst)        bus.pc <= 32'h0;
    else if (bus.cpu_en) bus.pc <= bus.pc + 32'd4;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    core_rst    = 1'b1;
    run_sw      = 1'b0;
    step_btn_n  = 1'b1;
    bus.bp_en   = 1'b0;
    bus.bp_addr = 32'h0;
    bus.instr   = NOP;
    cyc();
    cyc();
    rst      = 1'b0;
    core_rst = 1'b0;
    cyc();
  endtask

  initial begin
    int first;
    int np;

    // 1: reset with arbitrary inputs
    rst         = 1'b1;
    core_rst    = 1'b1;
    step_btn_n  = 1'b0;
    run_sw      = 1'b1;
    bus.bp_en   = 1'b1;
    bus.bp_addr = 32'h0;
    bus.instr   = EBREAK_INSTR;
    cyc();
    cyc();
    check_val("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
    check_val("rst_state",  32'(bus.state), 32'd0);
    check_val("rst_halted", 32'(bus.halted), 32'd1);
    check_val("rst_count",  bus.instr_count, 32'd0);

    // 2: single step, then a short glitch
    do_reset();
    step_btn_n = 1'b0;
    first = 0;
    np    = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (bus.cpu_en) begin
        np++;
        if (first == 0) first = i;
      end
      if (i == 6) check_val("step_state_step", 32'(bus.state), 32'd2);
      if (i == 7) check_val("step_state_halt", 32'(bus.state), 32'd0);
    end
    step_btn_n = 1'b1;
    repeat (10) cyc();
    check_val("step_first_pulse", 32'(first), 32'd6);
    check_val("step_npulses", 32'(np), 32'd1);
    check_val("step_count", bus.instr_count, 32'd1);
    check_val("step_pc", bus.pc, 32'h4);

    step_btn_n = 1'b0;
    repeat (3) cyc();
    step_btn_n = 1'b1;
    np = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (bus.cpu_en) np++;
    end
    check_val("glitch_npulses", 32'(np), 32'd0);
    check_val("glitch_count", bus.instr_count, 32'd1);

    // 3: free-run, pulse every third cycle
    do_reset();
    run_sw = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      check_val($sformatf("run_pulse_%0d", i), 32'(bus.cpu_en),
                32'((i >= 6) && ((i - 6) % 3 == 0)));
    end
    check_val("run_halted", 32'(bus.halted), 32'd0);
    cyc();
    check_val("run_count", bus.instr_count, 32'd4);
    check_val("run_pc", bus.pc, 32'h10);

    // 4: breakpoint at 0x10, then step past it
    do_reset();
    bus.bp_en   = 1'b1;
    bus.bp_addr = 32'h10;
    run_sw      = 1'b1;
    np = 0;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      if (bus.cpu_en) np++;
    end
    cyc();
    check_val("bp_npulses", 32'(np), 32'd4);
    check_val("bp_state", 32'(bus.state), 32'd3);
    check_val("bp_pc", bus.pc, 32'h10);
    check_val("bp_halted", 32'(bus.halted), 32'd1);
    np = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.cpu_en) np++;
    end
    check_val("bp_hold_npulses", 32'(np), 32'd0);
    check_val("bp_hold_state", 32'(bus.state), 32'd3);
    step_btn_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 6) begin
        check_val("bp_step_en", 32'(bus.cpu_en), 32'd1);
        check_val("bp_step_state", 32'(bus.state), 32'd2);
      end
      if (i == 7) begin
        check_val("bp_step_pc", bus.pc, 32'h14);
        check_val("bp_step_halt", 32'(bus.state), 32'd0);
      end
      if (i == 8) check_val("bp_resume_run", 32'(bus.state), 32'd1);
    end
    step_btn_n = 1'b1;

    // 5: EBREAK stops free-run, run switch off returns to HALT
    do_reset();
    run_sw = 1'b1;
    for (int i = 1; i <= 6; i++) cyc();
    check_val("ebrk_first_pulse", 32'(bus.cpu_en), 32'd1);
    bus.instr = EBREAK_INSTR;
    np = 0;
    for (int i = 7; i <= 9; i++) begin
      cyc();
      if (bus.cpu_en) np++;
    end
    check_val("ebrk_npulses", 32'(np), 32'd0);
    check_val("ebrk_state", 32'(bus.state), 32'd3);
    check_val("ebrk_halted", 32'(bus.halted), 32'd1);
    check_val("ebrk_pc", bus.pc, 32'h4);
    run_sw = 1'b0;
    cyc();
    cyc();
    check_val("ebrk_sync_hold", 32'(bus.state), 32'd3);
    cyc();
    check_val("ebrk_to_halt", 32'(bus.state), 32'd0);

    // 6: reset lands on a tick cycle
    do_reset();
    run_sw = 1'b1;
    for (int i = 1; i <= 8; i++) cyc();
    check_val("rsttick_pre_count", bus.instr_count, 32'd1);
    rst = 1'b1;
    cyc();
    check_val("rsttick_cpu_en", 32'(bus.cpu_en), 32'd0);
    check_val("rsttick_state", 32'(bus.state), 32'd0);
    check_val("rsttick_count", bus.instr_count, 32'd0);
    rst    = 1'b0;
    run_sw = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
